// File: rtl/secure_seq_fsm.sv
// -----------------------------------------------------------------------------
// secure_seq_fsm
//   Security-gated sequencing controller. A start request is accepted only
//   while secure_i is high. The block then walks ARM -> RUN (RUN_CYCLES long)
//   -> DONE -> IDLE. Loss of secure_i before the sequence finishes aborts to
//   ERR and bumps a saturating violation counter that only reset clears.
//
//   Build option: define SEC_SEQ_LOCK_EN to make ERR sticky. ERR is then
//   released only by err_clr_i=1 together with start_i=0. Without the macro,
//   ERR lasts one cycle and err_clr_i is ignored.
//
// Ports
//   clk          clock
//   rst_n        asynchronous active-low reset
//   secure_i     security-qualified enable, must stay high for a whole sequence
//   start_i      sequence request, sampled only in IDLE
//   err_clr_i    error-lock release (SEC_SEQ_LOCK_EN builds only)
//   busy_o       high in ARM and RUN
//   done_o       one-cycle pulse in DONE
//   err_o        high in ERR
//   phase_o      state code: IDLE=0 ARM=1 RUN=2 DONE=3 ERR=4
//   remaining_o  RUN cycles still to go (counter+1), 0 outside RUN
//   viol_cnt_o   saturating count of security violations
//
// State table
//   state | meaning
//   IDLE  | waiting for start_i
//   ARM   | request accepted, one setup cycle, loads RUN counter
//   RUN   | counting down RUN_CYCLES cycles
//   DONE  | sequence finished, done_o pulses
//   ERR   | security violation (or illegal encoding) recovery
// -----------------------------------------------------------------------------
module secure_seq_fsm #(
    parameter int RUN_CYCLES = 4,
    parameter int CNT_W      = $clog2(RUN_CYCLES + 1),
    parameter int VIOL_W     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              secure_i,
    input  logic              start_i,
    input  logic              err_clr_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [2:0]        phase_o,
    output logic [CNT_W-1:0]  remaining_o,
    output logic [VIOL_W-1:0] viol_cnt_o
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        RUN  = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0]  RUN_LOAD = CNT_W'(RUN_CYCLES - 1);
    localparam logic [VIOL_W-1:0] VIOL_MAX = {VIOL_W{1'b1}};

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [VIOL_W-1:0] viol_q, viol_d;
    logic              viol_hit;

`ifndef SEC_SEQ_LOCK_EN
    // err_clr_i only matters for the sticky-error build.
    logic unused_err_clr;
    assign unused_err_clr = err_clr_i;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            viol_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            viol_q  <= viol_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        viol_hit = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (secure_i) begin
                        state_d = ARM;
                    end else begin
                        state_d  = ERR;
                        viol_hit = 1'b1;
                    end
                end
            end
            ARM: begin
                if (secure_i) begin
                    state_d = RUN;
                    cnt_d   = RUN_LOAD;
                end else begin
                    state_d  = ERR;
                    viol_hit = 1'b1;
                end
            end
            RUN: begin
                // Security loss wins over counter expiry.
                if (!secure_i) begin
                    state_d  = ERR;
                    cnt_d    = '0;
                    viol_hit = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            ERR: begin
`ifdef SEC_SEQ_LOCK_EN
                if (err_clr_i && !start_i) begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            default: begin
                // Corrupted encoding: recover through ERR, not a violation.
                state_d = ERR;
                cnt_d   = '0;
            end
        endcase
        viol_d = (viol_hit && (viol_q != VIOL_MAX)) ? viol_q + VIOL_W'(1) : viol_q;
    end

    always_comb begin
        busy_o      = (state_q == ARM) || (state_q == RUN);
        done_o      = (state_q == DONE);
        err_o       = (state_q == ERR);
        phase_o     = state_q;
        remaining_o = (state_q == RUN) ? cnt_q + CNT_W'(1) : '0;
        viol_cnt_o  = viol_q;
    end

endmodule

// File: tb/tb_secure_seq_fsm.sv
module tb_secure_seq_fsm;

`ifdef SEC_SEQ_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic       clk, rst_n;
    logic       secure, start, err_clr;
    logic       busy, done, err;
    logic [2:0] phase;
    logic [2:0] remaining;
    logic [3:0] viol;

    // second instance with a 2-bit violation counter for saturation
    logic       secure2, start2, err_clr2;
    logic       busy2, done2, err2;
    logic [2:0] phase2;
    logic [2:0] remaining2;
    logic [1:0] viol2;

    int checks = 0;
    int errors = 0;

    secure_seq_fsm #(.RUN_CYCLES(4), .VIOL_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .secure_i(secure), .start_i(start),
        .err_clr_i(err_clr), .busy_o(busy), .done_o(done), .err_o(err),
        .phase_o(phase), .remaining_o(remaining), .viol_cnt_o(viol)
    );

    secure_seq_fsm #(.RUN_CYCLES(4), .VIOL_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .secure_i(secure2), .start_i(start2),
        .err_clr_i(err_clr2), .busy_o(busy2), .done_o(done2), .err_o(err2),
        .phase_o(phase2), .remaining_o(remaining2), .viol_cnt_o(viol2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start, secure, err_clr;
        logic [2:0] phase;
        logic       busy, done, err;
        logic [2:0] rem;
        logic [3:0] viol;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic st, input logic se, input logic cl,
                       input logic [2:0] ph, input logic bz, input logic dn,
                       input logic er, input logic [2:0] rm, input logic [3:0] vc);
        vec_t v;
        v.start = st; v.secure = se; v.err_clr = cl;
        v.phase = ph; v.busy = bz; v.done = dn; v.err = er; v.rem = rm; v.viol = vc;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] ph, input logic bz,
                             input logic dn, input logic er, input logic [2:0] rm,
                             input logic [3:0] vc);
        check({tag, ".phase"}, int'(phase), int'(ph));
        check({tag, ".busy"}, int'(busy), int'(bz));
        check({tag, ".done"}, int'(done), int'(dn));
        check({tag, ".err"}, int'(err), int'(er));
        check({tag, ".remaining"}, int'(remaining), int'(rm));
        check({tag, ".viol"}, int'(viol), int'(vc));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic se, input logic cl);
        start = st; secure = se; err_clr = cl;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0);
        start2 = 0; secure2 = 0; err_clr2 = 0;

        // ---------------- table: inputs before edge, outputs after edge -----
        //  st se cl  ph bz dn er rm vc
        add(1, 1, 0,  1, 1, 0, 0, 0, 0);   // nominal: ARM
        add(0, 1, 0,  2, 1, 0, 0, 4, 0);
        add(0, 1, 0,  2, 1, 0, 0, 3, 0);
        add(0, 1, 0,  2, 1, 0, 0, 2, 0);
        add(0, 1, 0,  2, 1, 0, 0, 1, 0);
        add(0, 1, 0,  3, 0, 1, 0, 0, 0);   // DONE pulse
        add(0, 1, 0,  0, 0, 0, 0, 0, 0);   // IDLE
        add(1, 0, 0,  4, 0, 0, 1, 0, 1);   // insecure start -> ERR, no ARM
        add(0, 1, 1,  0, 0, 0, 0, 0, 1);   // leaves ERR in either build
        add(1, 1, 0,  1, 1, 0, 0, 0, 1);   // mid-RUN abort sequence
        add(0, 1, 0,  2, 1, 0, 0, 4, 1);
        add(0, 1, 0,  2, 1, 0, 0, 3, 1);
        add(0, 0, 0,  4, 0, 0, 1, 0, 2);   // secure lost in 2nd RUN cycle
        add(0, 1, 1,  0, 0, 0, 0, 0, 2);
        add(1, 1, 0,  1, 1, 0, 0, 0, 2);   // start held high: retrigger
        add(1, 1, 0,  2, 1, 0, 0, 4, 2);
        add(1, 1, 0,  2, 1, 0, 0, 3, 2);
        add(1, 1, 0,  2, 1, 0, 0, 2, 2);
        add(1, 1, 0,  2, 1, 0, 0, 1, 2);
        add(1, 1, 0,  3, 0, 1, 0, 0, 2);
        add(1, 1, 0,  0, 0, 0, 0, 0, 2);   // DONE -> IDLE regardless of start
        add(1, 1, 0,  1, 1, 0, 0, 0, 2);   // re-armed next cycle
        add(0, 1, 0,  2, 1, 0, 0, 4, 2);
        add(0, 0, 0,  4, 0, 0, 1, 0, 3);   // abort in first RUN cycle
        add(0, 1, 1,  0, 0, 0, 0, 0, 3);
        add(1, 1, 0,  1, 1, 0, 0, 0, 3);
        add(0, 0, 0,  4, 0, 0, 1, 0, 4);   // abort from ARM
        add(0, 1, 1,  0, 0, 0, 0, 0, 4);

        // ---------------- reset state ----------------
        step();
        check_all("reset", 0, 0, 0, 0, 0, 0);
        check("reset.sat_viol", int'(viol2), 0);
        rst_n = 1'b1;
        step();
        check_all("post_reset", 0, 0, 0, 0, 0, 0);

        // ---------------- table-driven ----------------
        foreach (vecs[i]) begin
            drive(vecs[i].start, vecs[i].secure, vecs[i].err_clr);
            step();
            check_all($sformatf("vec%0d", i), vecs[i].phase, vecs[i].busy,
                      vecs[i].done, vecs[i].err, vecs[i].rem, vecs[i].viol);
        end

        // ---------------- ERR exit behaviour ----------------
        drive(1, 0, 0);
        step();
        check_all("lock.enter", 4, 0, 0, 1, 0, 5);
        drive(0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("lock.hold%0d.phase", i), int'(phase), LOCK ? 4 : 0);
        end
        drive(1, 1, 1);   // lock: clr ignored with start; no lock: IDLE -> ARM
        step();
        check("lock.clr_with_start.phase", int'(phase), LOCK ? 4 : 1);
        drive(0, 1, 1);   // lock: released; no lock: ARM -> RUN
        step();
        check("lock.release.phase", int'(phase), LOCK ? 0 : 2);
        check("lock.viol", int'(viol), 5);

        // ---------------- async reset during RUN ----------------
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        drive(0, 1, 0);
        step();
        drive(1, 0, 0);   // make viol_cnt nonzero so its reset is visible
        step();
        drive(0, 1, 1);
        step();
        drive(1, 1, 0);
        step();
        drive(0, 1, 0);
        step();
        step();
        step();
        check_all("ar.pre", 2, 1, 0, 0, 2, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("ar.async", 0, 0, 0, 0, 0, 0);
        step();
        check_all("ar.held", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        drive(1, 1, 0);
        step();
        check_all("ar.arm", 1, 1, 0, 0, 0, 0);
        drive(0, 1, 0);
        for (int r = 4; r >= 1; r--) begin
            step();
            check_all($sformatf("ar.run%0d", r), 2, 1, 0, 0, 3'(r), 0);
        end
        step();
        check_all("ar.done", 3, 0, 1, 0, 0, 0);
        step();
        check_all("ar.idle", 0, 0, 0, 0, 0, 0);

        // ---------------- saturation on 2-bit counter ----------------
        for (int k = 0; k < 5; k++) begin
            start2 = 1; secure2 = 0; err_clr2 = 0;
            step();
            check($sformatf("sat%0d.phase", k), int'(phase2), 4);
            check($sformatf("sat%0d.viol", k), int'(viol2), (k < 3) ? k + 1 : 3);
            start2 = 0; err_clr2 = 1;
            step();
            check($sformatf("sat%0d.idle", k), int'(phase2), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
